// File: rtl/echo_queue_if.sv
// echo_queue_if
//   Request/indication handshake bundle for echo_queue.
//   slave  : the queue side (takes requests, drives indications).
//   master : the host/sink side (drives requests, takes indications).
//   request_*    : say / say2 / setLeds enqueue requests with ENA/RDY.
//   indication_* : heard / heard2 replays with ENA/RDY.
interface echo_queue_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int HW = DATA_WIDTH / 2;

  logic                  request_say__ENA;
  logic [DATA_WIDTH-1:0] request_say_v;
  logic                  request_say__RDY;
  logic                  request_say2__ENA;
  logic [HW-1:0]         request_say2_a;
  logic [HW-1:0]         request_say2_b;
  logic                  request_say2__RDY;
  logic                  request_setLeds__ENA;
  logic [7:0]            request_setLeds_v;
  logic                  request_setLeds__RDY;

  logic                  indication_heard__ENA;
  logic [DATA_WIDTH-1:0] indication_heard_v;
  logic                  indication_heard__RDY;
  logic                  indication_heard2__ENA;
  logic [HW-1:0]         indication_heard2_a;
  logic [HW-1:0]         indication_heard2_b;
  logic                  indication_heard2__RDY;

  modport slave (
    input  request_say__ENA, request_say_v,
    output request_say__RDY,
    input  request_say2__ENA, request_say2_a, request_say2_b,
    output request_say2__RDY,
    input  request_setLeds__ENA, request_setLeds_v,
    output request_setLeds__RDY,
    output indication_heard__ENA, indication_heard_v,
    input  indication_heard__RDY,
    output indication_heard2__ENA, indication_heard2_a, indication_heard2_b,
    input  indication_heard2__RDY
  );

  modport master (
    output request_say__ENA, request_say_v,
    input  request_say__RDY,
    output request_say2__ENA, request_say2_a, request_say2_b,
    input  request_say2__RDY,
    output request_setLeds__ENA, request_setLeds_v,
    input  request_setLeds__RDY,
    input  indication_heard__ENA, indication_heard_v,
    output indication_heard__RDY,
    input  indication_heard2__ENA, indication_heard2_a, indication_heard2_b,
    output indication_heard2__RDY
  );
endinterface

// File: rtl/echo_queue.sv
// echo_queue
//   DEPTH-entry in-order queue of say/say2 requests, replayed on heard/heard2,
//   plus an 8-bit LED register.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset (flushes the queue, clears leds)
//   bus   : echo_queue_if.slave request/indication handshakes
//   leds  : LED register
//   count : queue occupancy
//   Optional macro ECHO_QUEUE_STATS_EN adds stat_sent (pop counter, wraps)
//   and stat_dropped_say2 (rejected say2 counter, saturating).
module echo_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  echo_queue_if.slave            bus,
  output logic [7:0]             leds,
  output logic [$clog2(DEPTH):0] count
`ifdef ECHO_QUEUE_STATS_EN
  ,
  output logic [31:0]            stat_sent,
  output logic [15:0]            stat_dropped_say2
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry MSB is the type: 0 = say, 1 = say2.
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic                full, empty;
  logic                push_say, push_say2, push, pop;
  logic [DATA_WIDTH:0] wdata, head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // say wins a same-cycle collision, hence say2 RDY depends on say ENA.
  assign bus.request_say__RDY     = !full;
  assign bus.request_say2__RDY    = !full && !bus.request_say__ENA;
  assign bus.request_setLeds__RDY = 1'b1;

  assign push_say  = bus.request_say__ENA && bus.request_say__RDY;
  assign push_say2 = bus.request_say2__ENA && bus.request_say2__RDY;
  assign push      = push_say || push_say2;

  always_comb begin
    wdata = {1'b0, bus.request_say_v};
    if (!push_say)
      wdata = {1'b1, bus.request_say2_a, bus.request_say2_b};
  end

  // Head type gates the enables, so a say2 head blocks later say entries.
  assign bus.indication_heard__ENA  = !empty && !head[DATA_WIDTH] && bus.indication_heard__RDY;
  assign bus.indication_heard2__ENA = !empty &&  head[DATA_WIDTH] && bus.indication_heard2__RDY;
  assign bus.indication_heard_v     = head[DATA_WIDTH-1:0];
  assign bus.indication_heard2_a    = head[DATA_WIDTH-1:DATA_WIDTH/2];
  assign bus.indication_heard2_b    = head[DATA_WIDTH/2-1:0];
  assign pop = bus.indication_heard__ENA || bus.indication_heard2__ENA;

  // Payload storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      leds   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (bus.request_setLeds__ENA)
        leds <= bus.request_setLeds_v;
    end
  end

`ifdef ECHO_QUEUE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_sent         <= '0;
      stat_dropped_say2 <= '0;
    end else begin
      if (pop)
        stat_sent <= stat_sent + 32'd1;
      if (bus.request_say2__ENA && !bus.request_say2__RDY && stat_dropped_say2 != 16'hFFFF)
        stat_dropped_say2 <= stat_dropped_say2 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_echo_queue.sv
module tb_echo_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] leds;
  logic [$clog2(DEPTH):0] count;
`ifdef ECHO_QUEUE_STATS_EN
  logic [31:0] stat_sent;
  logic [15:0] stat_dropped;
`endif

  echo_queue_if #(.DATA_WIDTH(DW)) bus ();

  echo_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus.slave),
    .leds  (leds),
    .count (count)
`ifdef ECHO_QUEUE_STATS_EN
    ,
    .stat_sent         (stat_sent),
    .stat_dropped_say2 (stat_dropped)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is2;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  ent_t        e;
  logic [7:0]  mdl_leds;
  logic [31:0] mdl_sent;
  logic [15:0] mdl_dropped;
  bit          rst_seen = 0;
  bit          m_full, m_h, m_h2, m_say_rdy, m_say2_rdy;
  int          checks = 0;
  int          failures = 0;
  int          heard2_fires = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending requests, updated once per cycle.
  always @(negedge CLK) begin
    if (RST) begin
      mq.delete();
      mdl_leds    = 8'h00;
      mdl_sent    = 32'd0;
      mdl_dropped = 16'd0;
      rst_seen    = 1;
    end else if (rst_seen) begin
      m_full     = (mq.size() == DEPTH);
      m_say_rdy  = !m_full;
      m_say2_rdy = !m_full && !bus.request_say__ENA;
      m_h  = (mq.size() > 0) && !mq[0].is2 && bus.indication_heard__RDY;
      m_h2 = (mq.size() > 0) &&  mq[0].is2 && bus.indication_heard2__RDY;
      chk("count", 64'(count), 64'(mq.size()));
      chk("leds", 64'(leds), 64'(mdl_leds));
      chk("say_rdy", 64'(bus.request_say__RDY), 64'(m_say_rdy));
      chk("say2_rdy", 64'(bus.request_say2__RDY), 64'(m_say2_rdy));
      chk("setleds_rdy", 64'(bus.request_setLeds__RDY), 64'(1));
      chk("heard_ena", 64'(bus.indication_heard__ENA), 64'(m_h));
      chk("heard2_ena", 64'(bus.indication_heard2__ENA), 64'(m_h2));
`ifdef ECHO_QUEUE_STATS_EN
      chk("stat_sent", 64'(stat_sent), 64'(mdl_sent));
      chk("stat_dropped", 64'(stat_dropped), 64'(mdl_dropped));
`endif
      if (bus.indication_heard__ENA || bus.indication_heard2__ENA) begin
        if (mq.size() == 0) begin
          chk("pop_from_empty", 64'(1), 64'(0));
        end else begin
          e = mq.pop_front();
          if (bus.indication_heard__ENA)
            chk("heard_v", 64'(bus.indication_heard_v), 64'(e.d));
          else begin
            heard2_fires++;
            chk("heard2_ab", 64'({bus.indication_heard2_a, bus.indication_heard2_b}), 64'(e.d));
          end
          mdl_sent = mdl_sent + 32'd1;
        end
      end
      if (bus.request_say__ENA && m_say_rdy)
        mq.push_back('{is2: 1'b0, d: bus.request_say_v});
      else if (bus.request_say2__ENA && m_say2_rdy)
        mq.push_back('{is2: 1'b1, d: {bus.request_say2_a, bus.request_say2_b}});
      if (bus.request_say2__ENA && !m_say2_rdy && mdl_dropped != 16'hFFFF)
        mdl_dropped = mdl_dropped + 16'd1;
      if (bus.request_setLeds__ENA)
        mdl_leds = bus.request_setLeds_v;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clr();
    bus.request_say__ENA     = 0;
    bus.request_say2__ENA    = 0;
    bus.request_setLeds__ENA = 0;
    RST = 0;
  endtask

  task automatic say(input logic [31:0] v);
    bus.request_say__ENA = 1;
    bus.request_say_v    = v;
  endtask

  task automatic say2(input logic [15:0] a, input logic [15:0] b);
    bus.request_say2__ENA = 1;
    bus.request_say2_a    = a;
    bus.request_say2_b    = b;
  endtask

  initial begin
    bus.request_say_v      = '0;
    bus.request_say2_a     = '0;
    bus.request_say2_b     = '0;
    bus.request_setLeds_v  = '0;
    bus.request_say__ENA   = 0;
    bus.request_say2__ENA  = 0;
    bus.request_setLeds__ENA = 0;
    bus.indication_heard__RDY  = 1;
    bus.indication_heard2__RDY = 1;
    RST = 1;
    step(2);
    clr();
    step(1);

    // Single say replayed one cycle later.
    say(32'h12345678); step(1); clr(); step(3);

    // say2 held behind a stalled sink.
    bus.indication_heard2__RDY = 0;
    say2(16'hAAAA, 16'h5555); step(1); clr(); step(3);
    bus.indication_heard2__RDY = 1; step(3);
    chk("heard2_count_after_release", 64'(heard2_fires), 64'(1));

    // Fill with alternating types while both sinks are stalled, then drain.
    bus.indication_heard__RDY  = 0;
    bus.indication_heard2__RDY = 0;
    for (int i = 0; i < DEPTH; i++) begin
      clr();
      if (i % 2 == 0) say(32'hC000_0000 + i); else say2(16'hB000 + 16'(i), 16'h0B00 + 16'(i));
      step(1);
    end
    clr();
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_say_rdy", 64'(bus.request_say__RDY), 64'(0));
    chk("full_say2_rdy", 64'(bus.request_say2__RDY), 64'(0));
    bus.indication_heard__RDY  = 1;
    bus.indication_heard2__RDY = 1;
    step(6);

    // Pointer wrap with random sink stalls.
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      clr();
      if (i % 3 == 2) say2(16'($urandom), 16'($urandom)); else say($urandom);
      bus.indication_heard__RDY  = ($urandom_range(0, 3) != 0);
      bus.indication_heard2__RDY = ($urandom_range(0, 3) != 0);
      step(1);
    end
    clr();
    bus.indication_heard__RDY  = 1;
    bus.indication_heard2__RDY = 1;
    step(DEPTH + 2);

    // Same-cycle collision: say wins.
    say(32'd1); say2(16'h1111, 16'h2222); step(1); clr(); step(3);

    // Full queue, then pop while pushing.
    bus.indication_heard__RDY = 0;
    for (int i = 0; i < DEPTH; i++) begin
      clr(); say(32'hF000_0000 + i); step(1);
    end
    clr();
    say(32'hF00D_0001); bus.indication_heard__RDY = 1; step(1);
    clr(); say(32'hF00D_0002); step(1);
    clr(); step(DEPTH + 3);

    // Flush by reset.
    bus.indication_heard__RDY  = 0;
    bus.indication_heard2__RDY = 0;
    bus.request_setLeds__ENA = 1; bus.request_setLeds_v = 8'h5A; step(1); clr();
    for (int i = 0; i < 3; i++) begin
      clr(); if (i == 1) say2(16'hDEAD, 16'hBEEF); else say(32'hDEAD_0000 + i); step(1);
    end
    clr();
    RST = 1; step(1); clr();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_leds", 64'(leds), 64'(0));
    bus.indication_heard__RDY  = 1;
    bus.indication_heard2__RDY = 1;
    step(5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      clr();
      if ($urandom_range(0, 2) == 0) say($urandom);
      if ($urandom_range(0, 2) == 0) say2(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        bus.request_setLeds__ENA = 1;
        bus.request_setLeds_v    = 8'($urandom);
      end
      bus.indication_heard__RDY  = ($urandom_range(0, 9) < 7);
      bus.indication_heard2__RDY = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 149) == 0) RST = 1;
      step(1);
    end
    clr();
    bus.indication_heard__RDY  = 1;
    bus.indication_heard2__RDY = 1;
    step(DEPTH + 4);
    chk("drained_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
